// File: rtl/tex_env_chain_if.sv
// tex_env_chain_if: config, pixel-in and pixel-out channels of tex_env_chain.
interface tex_env_chain_if #(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int TEX_UNITS = 2,
    parameter int USER_WIDTH = 16
);
    localparam int PW = 4 * SUB_PIXEL_WIDTH;
    localparam int UNIT_W = TEX_UNITS > 1 ? $clog2(TEX_UNITS) : 1;
    logic cfg_wr;
    logic [UNIT_W-1:0] cfg_unit;
    logic [2:0] cfg_func;
    logic [PW-1:0] cfg_env_color;
    logic cfg_pending;
    logic s_valid;
    logic s_ready;
    logic [PW-1:0] s_primary_color;
    logic [TEX_UNITS*PW-1:0] s_tex_color;
    logic [USER_WIDTH-1:0] s_user;
    logic m_valid;
    logic m_ready;
    logic [PW-1:0] m_color;
    logic [USER_WIDTH-1:0] m_user;
    modport master (
        output cfg_wr, cfg_unit, cfg_func, cfg_env_color, s_valid, s_primary_color, s_tex_color, s_user, m_ready,
        input cfg_pending, s_ready, m_valid, m_color, m_user
    );
    modport slave (
        input cfg_wr, cfg_unit, cfg_func, cfg_env_color, s_valid, s_primary_color, s_tex_color, s_user, m_ready,
        output cfg_pending, s_ready, m_valid, m_color, m_user
    );
endinterface

// File: rtl/tex_env_chain.sv
// tex_env_chain: cascaded texture-environment combiners, two register stages per unit
// (normalised products, then saturating sum); config changes wait for the pipeline to drain.
module tex_env_chain #(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int TEX_UNITS = 2,
    parameter int USER_WIDTH = 16
) (
    input  logic aclk,
    input  logic reset,
    tex_env_chain_if.slave bus
);
    localparam int W = SUB_PIXEL_WIDTH;
    localparam int PW = 4 * W;
    localparam int TW = TEX_UNITS * PW;
    localparam int UNIT_W = TEX_UNITS > 1 ? $clog2(TEX_UNITS) : 1;
    localparam logic [W-1:0] ONE = '1;
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W:0] ONE1 = {1'b0, ONE};
    localparam logic [W:0] HALF1 = (W+1)'(1) << (W - 1);

    logic w_ce, w_busy, w_cfg_ok;
    logic [2*TEX_UNITS-1:0] w_vbits;
    logic w_v [TEX_UNITS+1];
    logic [PW-1:0] w_col [TEX_UNITS+1];
    logic [USER_WIDTH-1:0] w_u [TEX_UNITS+1];
    logic [TW-1:0] w_tex [TEX_UNITS];
    logic [2:0] r_func [TEX_UNITS];
    logic [PW-1:0] r_env [TEX_UNITS];
    logic r_pend;
    logic [UNIT_W-1:0] r_p_unit;
    logic [2:0] r_p_func;
    logic [PW-1:0] r_p_env;

    // x*y/ONE rounded so that ONE is the multiplicative identity
    function automatic logic [W-1:0] nmul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        p = p + (p >> W) + {{(2*W-1){1'b0}}, 1'b1};
        return p[2*W-1:W];
    endfunction

    assign w_ce = !bus.m_valid || bus.m_ready;
    assign w_busy = |w_vbits;
    assign w_cfg_ok = bus.cfg_wr && !r_pend && int'(bus.cfg_unit) < TEX_UNITS;
    assign bus.s_ready = w_ce && !r_pend && !bus.cfg_wr;
    assign bus.cfg_pending = r_pend;
    assign w_v[0] = bus.s_valid && bus.s_ready;
    assign w_col[0] = bus.s_primary_color;
    assign w_u[0] = bus.s_user;
    assign w_tex[0] = bus.s_tex_color;
    assign bus.m_valid = w_v[TEX_UNITS];
    assign bus.m_color = w_col[TEX_UNITS];
    assign bus.m_user = w_u[TEX_UNITS];

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TEX_UNITS; i++) begin
                r_func[i] <= '0;
                r_env[i] <= '0;
            end
            r_pend <= 1'b0;
            r_p_unit <= '0;
            r_p_func <= '0;
            r_p_env <= '0;
        end else if (w_cfg_ok && !w_busy) begin
            r_func[bus.cfg_unit] <= bus.cfg_func;
            r_env[bus.cfg_unit] <= bus.cfg_env_color;
        end else if (w_cfg_ok) begin
            r_pend <= 1'b1;
            r_p_unit <= bus.cfg_unit;
            r_p_func <= bus.cfg_func;
            r_p_env <= bus.cfg_env_color;
        end else if (r_pend && !w_busy) begin
            r_func[r_p_unit] <= r_p_func;
            r_env[r_p_unit] <= r_p_env;
            r_pend <= 1'b0;
        end
    end

    for (genvar k = 0; k < TEX_UNITS; k++) begin : g_unit
        logic r_pv, r_sv;
        logic [PW-1:0] r_t1, r_t2, r_c;
        logic [3:0] r_sg;
        logic [USER_WIDTH-1:0] r_pu, r_su;
        logic [PW-1:0] w_t1, w_t2, w_res;
        logic [3:0] w_sg;
        logic [PW-1:0] w_cp, w_cs, w_cc;
        logic [2:0] w_f;
        logic w_add;
        assign w_cp = w_col[k];
        assign w_cs = w_tex[k][PW-1:0];
        assign w_cc = r_env[k];
        assign w_f = r_func[k];
        assign w_add = w_f == 3'd5 || w_f == 3'd6;

        // each channel: A*B + C*D, alpha only ever uses the first product
        for (genvar c = 0; c < 4; c++) begin : g_ch
            localparam bit IS_A = c == 0;
            logic [W-1:0] w_x, w_s, w_e, w_as, w_oa, w_ob, w_oc, w_od, w_off_c;
            logic [W:0] w_sum, w_off;
            assign w_x = w_cp[c*W +: W];
            assign w_s = w_cs[c*W +: W];
            assign w_e = w_cc[c*W +: W];
            assign w_as = w_cs[W-1:0];
            assign w_oa = w_f == 3'd1 ? w_s : w_x;
            assign w_ob = IS_A ? ((w_f == 3'd2 || w_f == 3'd4 || w_add) ? w_s : ONE)
                        : w_f == 3'd2 ? w_s : w_f == 3'd3 ? ONE - w_as : w_f == 3'd4 ? ONE - w_s : ONE;
            assign w_oc = IS_A ? ZERO : (w_f == 3'd3 || w_add) ? w_s : w_f == 3'd4 ? w_e : ZERO;
            assign w_od = IS_A ? ZERO : w_f == 3'd3 ? w_as : w_f == 3'd4 ? w_s : w_add ? ONE : ZERO;
            assign w_t1[c*W +: W] = nmul(w_oa, w_ob);
            assign w_t2[c*W +: W] = nmul(w_oc, w_od);
            assign w_sg[c] = !IS_A && w_f == 3'd6;
            assign w_sum = {1'b0, r_t1[c*W +: W]} + {1'b0, r_t2[c*W +: W]};
            assign w_off = w_sum - HALF1;
            assign w_off_c = w_sum < HALF1 ? ZERO : w_off > ONE1 ? ONE : w_off[W-1:0];
            assign w_res[c*W +: W] = r_sg[c] ? w_off_c : w_sum > ONE1 ? ONE : w_sum[W-1:0];
        end

        always_ff @(posedge aclk or posedge reset) begin
            if (reset) begin
                r_pv <= 1'b0;
                r_sv <= 1'b0;
                r_t1 <= '0;
                r_t2 <= '0;
                r_sg <= '0;
                r_c <= '0;
                r_pu <= '0;
                r_su <= '0;
            end else if (w_ce) begin
                r_pv <= w_v[k];
                r_pu <= w_u[k];
                r_t1 <= w_t1;
                r_t2 <= w_t2;
                r_sg <= w_sg;
                r_sv <= r_pv;
                r_su <= r_pu;
                r_c <= w_res;
            end
        end

        // texels for later units ride along, consumed slice dropped at each unit
        if (k < TEX_UNITS - 1) begin : g_fw
            logic [TW-1:0] r_ptex, r_stex;
            always_ff @(posedge aclk or posedge reset) begin
                if (reset) begin
                    r_ptex <= '0;
                    r_stex <= '0;
                end else if (w_ce) begin
                    r_ptex <= w_tex[k] >> PW;
                    r_stex <= r_ptex;
                end
            end
            assign w_tex[k+1] = r_stex;
        end

        assign w_vbits[2*k] = r_pv;
        assign w_vbits[2*k+1] = r_sv;
        assign w_v[k+1] = r_sv;
        assign w_col[k+1] = r_c;
        assign w_u[k+1] = r_su;
    end
endmodule

// File: tb/tb_tex_env_chain.sv
// tb_tex_env_chain: randomized + directed stimulus, scoreboard checked against a per-channel arithmetic model.
module tb_tex_env_chain;
    localparam int W = 8;
    localparam int TU = 2;
    localparam int UW = 16;
    typedef struct packed {
        logic [31:0] c;
        logic [15:0] u;
    } exp_t;

    logic aclk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int ready_mode = 0;
    logic [15:0] user_ctr = 16'h0;
    int m_func[TU];
    logic [31:0] m_env[TU];

    tex_env_chain_if #(.SUB_PIXEL_WIDTH(W), .TEX_UNITS(TU), .USER_WIDTH(UW)) bus ();
    tex_env_chain #(.SUB_PIXEL_WIDTH(W), .TEX_UNITS(TU), .USER_WIDTH(UW)) dut (
        .aclk(aclk),
        .reset(reset),
        .bus(bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int nm(input int x, input int y);
        int p = x * y;
        return (p + (p >> 8) + 1) >> 8;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] cf, input logic [63:0] tex);
        logic [31:0] cp = cf;
        logic [31:0] nx = 32'h0;
        for (int u = 0; u < TU; u++) begin
            for (int i = 0; i < 4; i++) begin
                int p, s, e, as, r;
                bit al;
                p = int'(cp[i*8 +: 8]);
                s = int'(tex[u*32 + i*8 +: 8]);
                e = int'(m_env[u][i*8 +: 8]);
                as = int'(tex[u*32 +: 8]);
                al = i == 0;
                case (m_func[u])
                    1: r = s;
                    2: r = nm(p, s);
                    3: r = al ? p : nm(p, 255 - as) + nm(s, as);
                    4: r = al ? nm(p, s) : nm(p, 255 - s) + nm(e, s);
                    5: r = al ? nm(p, s) : p + s;
                    6: r = al ? nm(p, s) : p + s - 128;
                    default: r = p;
                endcase
                nx[i*8 +: 8] = 8'(r < 0 ? 0 : r > 255 ? 255 : r);
            end
            cp = nx;
        end
        return cp;
    endfunction

    task automatic cfg_write(input int u, input int f, input logic [31:0] e, input bit apply);
        bus.cfg_wr = 1'b1;
        bus.cfg_unit = 1'(u);
        bus.cfg_func = 3'(f);
        bus.cfg_env_color = e;
        @(posedge aclk);
        #1;
        bus.cfg_wr = 1'b0;
        if (apply) begin
            m_func[u] = f;
            m_env[u] = e;
        end
    endtask

    task automatic send(input logic [31:0] cf, input logic [63:0] tex, input logic [31:0] expv);
        int t = 0;
        exp_t it;
        bus.s_valid = 1'b1;
        bus.s_primary_color = cf;
        bus.s_tex_color = tex;
        bus.s_user = user_ctr;
        do begin
            @(negedge aclk);
            t++;
        end while (!bus.s_ready && t < 300);
        if (!bus.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready got 0 expected 1");
        end
        @(posedge aclk);
        #1;
        if (t < 300) begin
            it.c = expv;
            it.u = user_ctr;
            sb.push_back(it);
        end
        bus.s_valid = 1'b0;
        user_ctr++;
    endtask

    task automatic send_rand();
        logic [31:0] cf;
        logic [63:0] tex;
        cf = $urandom;
        tex = {$urandom, $urandom};
        send(cf, tex, model(cf, tex));
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || bus.m_valid) && t < 500) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs outstanding expected 0", sb.size());
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            bus.m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic pv = 1'b0;
        logic [31:0] pc = 32'h0;
        logic [15:0] pu = 16'h0;
        exp_t e;
        forever begin
            @(negedge aclk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    check("stall_color", bus.m_color, pc);
                    check("stall_user", bus.m_user, pu);
                end
                if (bus.m_valid && !bus.m_ready) check("stall_s_ready", bus.s_ready, 0);
                if (bus.m_valid && bus.m_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h expected no output", bus.m_color);
                    end else begin
                        e = sb.pop_front();
                        check("color", bus.m_color, e.c);
                        check("user", bus.m_user, e.u);
                    end
                end
                pv = bus.m_valid && !bus.m_ready;
                pc = bus.m_color;
                pu = bus.m_user;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] tex;
        bus.cfg_wr = 1'b0;
        bus.cfg_unit = '0;
        bus.cfg_func = '0;
        bus.cfg_env_color = '0;
        bus.s_valid = 1'b0;
        bus.s_primary_color = '0;
        bus.s_tex_color = '0;
        bus.s_user = '0;
        for (int i = 0; i < TU; i++) begin
            m_func[i] = 0;
            m_env[i] = 32'h0;
        end
        repeat (2) @(negedge aclk);
        check("reset_m_valid", bus.m_valid, 0);
        check("reset_cfg_pending", bus.cfg_pending, 0);
        check("reset_m_color", bus.m_color, 0);
        check("reset_m_user", bus.m_user, 0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(negedge aclk);
        check("s_ready_after_reset", bus.s_ready, 1);
        @(posedge aclk);
        #1;

        cfg_write(0, 2, 32'h0, 1);
        cfg_write(1, 5, 32'h0, 1);
        send(32'h80808080, {32'h40404040, 32'hFFFFFFFF}, 32'hC0C0C020);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!bus.m_valid && n < 50);
        check("latency", n, 2 * TU);
        drain();

        cfg_write(0, 5, 32'h0, 1);
        cfg_write(1, 0, 32'h0, 1);
        send(32'hF0F0F0FF, {32'h12345678, 32'h404040FF}, 32'hFFFFFFFF);
        drain();
        cfg_write(0, 6, 32'h0, 1);
        send(32'h20202080, {32'h9ABCDEF0, 32'h404040FF}, 32'h00000080);
        drain();

        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int u = 0; u < TU; u++) cfg_write(u, $urandom_range(0, 7), $urandom, 1);
            for (int p = 0; p < 20; p++) begin
                send_rand();
                repeat ($urandom_range(0, 2)) begin
                    @(posedge aclk);
                    #1;
                end
            end
            drain();
        end

        ready_mode = 0;
        cfg_write(0, 4, 32'h3366CC99, 1);
        cfg_write(1, 3, 32'h0, 1);
        fork
            for (int p = 0; p < 8; p++) send_rand();
            begin
                repeat (5) @(posedge aclk);
                ready_mode = 2;
                repeat (3) @(posedge aclk);
                ready_mode = 0;
            end
        join
        drain();

        cfg_write(0, 2, 32'h0, 1);
        cfg_write(1, 0, 32'h0, 1);
        for (int p = 0; p < 3; p++) send_rand();
        cfg_write(0, 1, 32'h0, 1);
        check("pending_set", bus.cfg_pending, 1);
        check("pending_s_ready", bus.s_ready, 0);
        cfg_write(1, 1, 32'h0, 0);
        check("pending_held", bus.cfg_pending, 1);
        tex = {$urandom, $urandom};
        send(32'h55AA33CC, tex, tex[31:0]);
        check("pending_cleared", bus.cfg_pending, 0);
        drain();

        cfg_write(0, 2, 32'h0, 1);
        cfg_write(1, 5, 32'h0, 1);
        ready_mode = 2;
        @(posedge aclk);
        #1;
        for (int p = 0; p < 4; p++) send_rand();
        cfg_write(0, 1, 32'h0, 0);
        check("rst_pending_before", bus.cfg_pending, 1);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < TU; i++) begin
            m_func[i] = 0;
            m_env[i] = 32'h0;
        end
        #1;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_cfg_pending", bus.cfg_pending, 0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        ready_mode = 0;
        @(negedge aclk);
        check("rst_s_ready", bus.s_ready, 1);
        @(posedge aclk);
        #1;
        send(32'h11223344, {32'hCAFEF00D, 32'hDEADBEEF}, 32'h11223344);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tex_env_chain.md
TEX_ENV_CHAIN -- requirements
Module: tex_env_chain

Interface
REQ-001 SHALL have parameter SUB_PIXEL_WIDTH, default 8, bits per colour channel (W); ONE = all ones.
REQ-002 SHALL have parameter TEX_UNITS, default 2, number of cascaded texture-environment stages (1..8).
REQ-003 SHALL have parameter USER_WIDTH, default 16, sideband bits carried alongside each pixel.
REQ-004 Pixel words (PW = 4*W) SHALL pack R in bits [4W-1:3W], G in [3W-1:2W], B in [2W-1:W], A in [W-1:0].
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cfg_wr  in  1  config write strobe.
REQ-008 cfg_unit  in  max(1,clog2(TEX_UNITS))  target stage.
REQ-009 cfg_func  in  3  0 DISABLE, 1 REPLACE, 2 MODULATE, 3 DECAL, 4 BLEND, 5 ADD, 6 ADD_SIGNED, 7 reserved.
REQ-010 cfg_env_color  in  PW  environment colour Cc for the target stage.
REQ-011 cfg_pending  out  1  a write is waiting for the pipeline to drain.
REQ-012 s_valid / s_ready  in / out  1 / 1  input handshake.
REQ-013 s_primary_color  in  PW  fragment colour Cf.
REQ-014 s_tex_color  in  TEX_UNITS*PW  texel Cs per stage; stage k at bits [k*PW +: PW].
REQ-015 s_user  in  USER_WIDTH  passthrough sideband.
REQ-016 m_valid / m_ready  out / in  1 / 1  output handshake.
REQ-017 m_color  out  PW  final combined colour.
REQ-018 m_user  out  USER_WIDTH  s_user of the same pixel.

Function
REQ-019 Stage k input Cp SHALL be Cf for k=0, else stage k-1 output; each stage SHALL compute per channel clamp(A*B + C*D) with operand selection per func.
REQ-020 DISABLE: Cp. REPLACE: Cs. MODULATE: Cp*Cs. DECAL: rgb Cp*(ONE-As)+Cs*As, alpha Ap. BLEND: rgb Cp*(ONE-Cs)+Cc*Cs, alpha Ap*As. ADD: rgb Cp+Cs, alpha Ap*As.
REQ-021 ADD_SIGNED SHALL give rgb clamp(Cp+Cs-2^(W-1)) to [0,ONE], alpha Ap*As; func 7 SHALL behave as DISABLE.
REQ-022 Each product x*y SHALL be normalised as (p + (p>>W) + 1) >> W with p = x*y (so ONE*ONE = ONE, 0x80*ONE = 0x80 at W=8).
REQ-023 The sum of two normalised terms SHALL saturate at ONE; no wrap-around.
REQ-024 Each stage SHALL take 2 register cycles (products, then sum/clamp); latency s accept -> m_valid SHALL be 2*TEX_UNITS cycles with m_ready high.
REQ-025 Pipeline SHALL advance (ce) iff !m_valid || m_ready; every stage holds a valid bit; order SHALL be preserved, bubbles not collapsed.
REQ-026 s_ready SHALL equal ce && !cfg_pending && !cfg_wr.
REQ-027 While m_valid && !m_ready, m_color and m_user SHALL hold stable.
REQ-028 Per-stage config registers: func (3 bits), env colour (PW bits).
REQ-029 cfg_wr with all valid bits 0 and !cfg_pending SHALL update the target stage at that edge.
REQ-030 cfg_wr with any valid bit set SHALL capture the write into a pending register and set cfg_pending on the next edge.
REQ-031 A pending write SHALL be applied at the first edge where all valid bits (m_valid included) are 0; cfg_pending SHALL clear at that edge.
REQ-032 cfg_wr while cfg_pending=1 SHALL be ignored.
REQ-033 cfg_wr with cfg_unit >= TEX_UNITS SHALL be ignored.
REQ-034 In-flight pixels SHALL always complete with the config in force when they were accepted.

Reset
REQ-035 Reset SHALL clear all valid bits, m_valid=0, cfg_pending=0, all funcs DISABLE, all env colours 0, m_color=0, m_user=0.
REQ-036 Reset mid-stream SHALL discard in-flight pixels and any pending write; s_ready=1 from the first edge after release.

Verification
REQ-037 TEX_UNITS=2, unit0 MODULATE, unit1 ADD; Cf=0x80808080, Cs0=0xFFFFFFFF, Cs1=0x40404040 -> m_color=0xC0C0C020, 4 cycles after accept.
REQ-038 Unit0 ADD, unit1 DISABLE; Cf=0xF0F0F0FF, Cs0=0x404040FF -> m_color=0xFFFFFFFF (rgb saturates, alpha 0xFF).
REQ-039 Unit0 ADD_SIGNED, unit1 DISABLE; Cf=0x20202080, Cs0=0x404040FF -> m_color=0x00000080.
REQ-040 Stream 8 pixels, drop m_ready for 3 cycles mid-burst -> all 8 delivered in order, m_color stable while stalled, s_ready=0 while stalled.
REQ-041 cfg_wr (unit0 -> REPLACE) with 3 pixels in flight -> cfg_pending=1, s_ready=0, the 3 pixels use the old func, then cfg_pending=0 and the next pixel outputs Cs0.
REQ-042 Assert reset with 4 pixels in flight and a write pending -> m_valid=0, cfg_pending=0, then Cf=0x11223344 passes unchanged (DISABLE).
